// File: rtl/conv_1d_if.sv
// conv_1d_if -- sample/result bus of the 1-D convolution engine.
//   feature : unsigned feature sample (4 bits), source -> engine
//   filter  : unsigned filter tap (4 bits), source -> engine
//   stride  : window step (4 bits), source -> engine
//   pad     : zero padding per side (4 bits), source -> engine
//   out     : convolution result modulo 256 (8 bits), engine -> sink
//   check   : result strobe, engine -> sink
// modport master: sample source / test driver; modport slave: the engine.
interface conv_1d_if;
  logic [3:0] feature;
  logic [3:0] filter;
  logic [3:0] stride;
  logic [3:0] pad;
  logic [7:0] out;
  logic       check;

  modport master (output feature, output filter, output stride, output pad,
                  input out, input check);
  modport slave  (input feature, input filter, input stride, input pad,
                  output out, output check);
endinterface

// File: rtl/conv_1d.sv
// conv_1d -- streaming 1-D correlation engine, one job per reset.
// Loads FEAT_LEN feature samples and then FILT_LEN filter taps, one sample
// every SAMPLE_DIV clocks, zero-pads the feature by `pad` on each side and
// emits one result per clock for every kernel window position.
// Ports:
//   clk : rising-edge clock
//   rst : asynchronous active-high reset, restarts the job
//   bus : conv_1d_if.slave (feature/filter/stride/pad in, out/check out)
module conv_1d #(
  parameter int FEAT_LEN   = 3,
  parameter int FILT_LEN   = 2,
  parameter int SAMPLE_DIV = 2
) (
  input  logic         clk,
  input  logic         rst,
  conv_1d_if.slave     bus
);

  localparam int SLOT_W  = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int XI_W    = (FEAT_LEN > 1) ? $clog2(FEAT_LEN) : 1;
  localparam int WI_W    = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
  // Buffers are sized to a power of two so any index value is in range.
  localparam int X_DEPTH = 2 ** XI_W;
  localparam int W_DEPTH = 2 ** WI_W;

  localparam logic [1:0] LOAD_FEAT = 2'd0;
  localparam logic [1:0] LOAD_FILT = 2'd1;
  localparam logic [1:0] COMPUTE   = 2'd2;
  localparam logic [1:0] DONE      = 2'd3;

  logic [1:0]        r_state;
  logic [SLOT_W-1:0] r_slot;
  logic [3:0]        r_idx;
  logic [3:0]        r_feat [X_DEPTH];
  logic [3:0]        r_tap  [W_DEPTH];
  logic [3:0]        r_pad;
  logic [3:0]        r_stride;
  // Start of the current window within the padded vector.
  logic [6:0]        r_pos;
  logic [7:0]        r_out;
  logic              r_check;

  logic              w_slot_last;
  logic [6:0]        w_plen;
  logic              w_win_ok;
  logic [7:0]        w_prod [FILT_LEN];
  logic [11:0]       w_sum;

  assign w_slot_last = (r_slot == SLOT_W'(SAMPLE_DIV - 1));
  assign w_plen      = 7'(FEAT_LEN) + {2'b00, r_pad, 1'b0};
  // Window positions are walked incrementally, so the output count never
  // needs a divider: the job ends when the window would overrun the padding.
  assign w_win_ok    = (r_pos + 7'(FILT_LEN)) <= w_plen;

  // One multiplier per tap; the padded sample is zero outside the feature.
  for (genvar gi = 0; gi < FILT_LEN; gi++) begin : g_tap
    logic [6:0] w_abs;
    logic [6:0] w_rel;
    logic [3:0] w_samp;

    assign w_abs = r_pos + 7'(gi);
    assign w_rel = w_abs - {3'b000, r_pad};

    always_comb begin
      w_samp = 4'd0;
      if ((w_abs >= {3'b000, r_pad}) && (w_rel < 7'(FEAT_LEN)))
        w_samp = r_feat[w_rel[XI_W-1:0]];
    end

    assign w_prod[gi] = {4'b0000, w_samp} * {4'b0000, r_tap[gi]};
  end

  always_comb begin
    w_sum = '0;
    for (int k = 0; k < FILT_LEN; k++)
      w_sum = w_sum + {4'b0000, w_prod[k]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= LOAD_FEAT;
      r_slot   <= '0;
      r_idx    <= '0;
      r_pad    <= '0;
      r_stride <= '0;
      r_pos    <= '0;
      r_out    <= '0;
      r_check  <= 1'b0;
      for (int i = 0; i < X_DEPTH; i++) r_feat[i] <= '0;
      for (int i = 0; i < W_DEPTH; i++) r_tap[i]  <= '0;
    end else begin
      case (r_state)
        LOAD_FEAT: begin
          r_slot <= w_slot_last ? '0 : r_slot + SLOT_W'(1);
          if (w_slot_last) begin
            r_feat[r_idx[XI_W-1:0]] <= bus.feature;
            // Job geometry is frozen at the very first capture.
            if (r_idx == 4'd0) begin
              r_pad    <= bus.pad;
              r_stride <= (bus.stride == 4'd0) ? 4'd1 : bus.stride;
            end
            if (r_idx == 4'(FEAT_LEN - 1)) begin
              r_idx   <= '0;
              r_state <= LOAD_FILT;
            end else begin
              r_idx <= r_idx + 4'd1;
            end
          end
        end
        LOAD_FILT: begin
          r_slot <= w_slot_last ? '0 : r_slot + SLOT_W'(1);
          if (w_slot_last) begin
            r_tap[r_idx[WI_W-1:0]] <= bus.filter;
            if (r_idx == 4'(FILT_LEN - 1)) begin
              r_idx   <= '0;
              r_pos   <= '0;
              r_state <= COMPUTE;
            end else begin
              r_idx <= r_idx + 4'd1;
            end
          end
        end
        COMPUTE: begin
          if (w_win_ok) begin
            r_out   <= w_sum[7:0];
            r_check <= 1'b1;
            r_pos   <= r_pos + {3'b000, r_stride};
          end else begin
            r_check <= 1'b0;
            r_state <= DONE;
          end
        end
        default: begin
          r_check <= 1'b0;
        end
      endcase
    end
  end

  assign bus.out   = r_out;
  assign bus.check = r_check;

endmodule

// File: tb/tb_conv_1d.sv
module tb_conv_1d;
  localparam int FEAT = 3;
  localparam int FILT = 2;
  localparam int DIV  = 2;
  localparam int FILT_B = 8;

  logic clk = 1'b0;
  logic rst_a = 1'b1;
  logic rst_b = 1'b1;

  conv_1d_if bus_a ();
  conv_1d_if bus_b ();

  conv_1d #(.FEAT_LEN(FEAT), .FILT_LEN(FILT), .SAMPLE_DIV(DIV)) u_dut_a (
    .clk (clk),
    .rst (rst_a),
    .bus (bus_a)
  );

  conv_1d #(.FEAT_LEN(FEAT), .FILT_LEN(FILT_B), .SAMPLE_DIV(DIV)) u_dut_b (
    .clk (clk),
    .rst (rst_b),
    .bus (bus_b)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int pulses_b = 0;
  int res_idx = 0;

  logic [3:0] feat_v [FEAT];
  logic [3:0] tap_v  [FILT];
  int exp_v [$];
  int sb_q  [$];

  task automatic cmp(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Reference: build the padded vector explicitly and correlate.
  task automatic model(input int p, input int s);
    int pv [$];
    int st;
    int sum;
    pv = {};
    exp_v = {};
    st = (s == 0) ? 1 : s;
    for (int i = 0; i < p; i++) pv.push_back(0);
    for (int i = 0; i < FEAT; i++) pv.push_back(int'(feat_v[i]));
    for (int i = 0; i < p; i++) pv.push_back(0);
    for (int j = 0; j * st + FILT <= pv.size(); j++) begin
      sum = 0;
      for (int k = 0; k < FILT; k++) sum += pv[j * st + k] * int'(tap_v[k]);
      exp_v.push_back(sum % 256);
    end
  endtask

  // Monitor: pop expected result whenever DUT A strobes check.
  always @(negedge clk) begin
    if (!rst_a && bus_a.check) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: got out=%0d, expected no result", bus_a.out);
      end else begin
        int e;
        e = sb_q.pop_front();
        $display("result %0d: out=%0d expected=%0d", res_idx, bus_a.out, e);
        res_idx++;
        cmp("result_value", int'(bus_a.out), e);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst_b && bus_b.check) pulses_b++;
  end

  task automatic do_reset_a();
    @(negedge clk);
    rst_a = 1'b1;
    repeat (2) @(negedge clk);
    cmp("reset_out", int'(bus_a.out), 0);
    cmp("reset_check", int'(bus_a.check), 0);
    sb_q.delete();
    res_idx = 0;
    rst_a = 1'b0;
  endtask

  // Loads one job, then either verifies the result window or aborts it with
  // an asynchronous reset during the third result.
  task automatic run_job(input logic [3:0] p, input logic [3:0] s, input bit abort);
    int last;
    $display("job: feat=%0d,%0d,%0d taps=%0d,%0d pad=%0d stride=%0d results=%0d",
             feat_v[0], feat_v[1], feat_v[2], tap_v[0], tap_v[1], p, s, exp_v.size());
    foreach (exp_v[i]) sb_q.push_back(exp_v[i]);
    last = (exp_v.size() > 0) ? exp_v[exp_v.size() - 1] : 0;
    for (int i = 0; i < FEAT; i++) begin
      bus_a.feature = feat_v[i];
      bus_a.filter  = 4'($urandom);
      if (i == 0) begin
        bus_a.pad    = p;
        bus_a.stride = s;
      end else begin
        bus_a.pad    = 4'($urandom);
        bus_a.stride = 4'($urandom);
      end
      repeat (DIV) @(negedge clk);
    end
    for (int i = 0; i < FILT; i++) begin
      bus_a.feature = 4'($urandom);
      bus_a.filter  = tap_v[i];
      bus_a.pad     = 4'($urandom);
      bus_a.stride  = 4'($urandom);
      repeat (DIV) @(negedge clk);
    end
    cmp("latency_gap", int'(bus_a.check), 0);
    if (abort) begin
      repeat (3) @(posedge clk);
      #1 rst_a = 1'b1;
      #1;
      cmp("async_rst_out", int'(bus_a.out), 0);
      cmp("async_rst_check", int'(bus_a.check), 0);
      sb_q.delete();
      return;
    end
    for (int j = 0; j < exp_v.size(); j++) begin
      @(negedge clk);
      cmp("check_high", int'(bus_a.check), 1);
    end
    @(negedge clk);
    cmp("check_fall", int'(bus_a.check), 0);
    repeat (2) @(negedge clk);
    cmp("done_out_hold", int'(bus_a.out), last);
    cmp("done_check", int'(bus_a.check), 0);
    cmp("sb_drain", sb_q.size(), 0);
  endtask

  task automatic set_base();
    feat_v[0] = 4'd3; feat_v[1] = 4'd2; feat_v[2] = 4'd1;
    tap_v[0]  = 4'd1; tap_v[1]  = 4'd2;
  endtask

  initial begin
    bus_a.feature = '0; bus_a.filter = '0; bus_a.pad = '0; bus_a.stride = '0;
    bus_b.feature = '0; bus_b.filter = '0; bus_b.pad = '0; bus_b.stride = '0;

    // Directed jobs with expectations taken straight from the worked examples.
    set_base();
    exp_v = {0, 6, 7, 4, 1, 0};
    do_reset_a(); run_job(4'd2, 4'd1, 1'b0);

    exp_v = {0, 7, 1};
    do_reset_a(); run_job(4'd2, 4'd2, 1'b0);

    exp_v = {7, 4};
    do_reset_a(); run_job(4'd0, 4'd0, 1'b0);

    feat_v[0] = 4'd15; feat_v[1] = 4'd15; feat_v[2] = 4'd15;
    tap_v[0]  = 4'd15; tap_v[1]  = 4'd15;
    exp_v = {194, 194};
    do_reset_a(); run_job(4'd0, 4'd1, 1'b0);

    // Reset in the middle of the result burst, then a clean rerun.
    set_base();
    exp_v = {0, 6, 7, 4, 1, 0};
    do_reset_a(); run_job(4'd2, 4'd1, 1'b1);
    exp_v = {0, 6, 7, 4, 1, 0};
    do_reset_a(); run_job(4'd2, 4'd1, 1'b0);

    // Randomized jobs against the reference model.
    for (int n = 0; n < 12; n++) begin
      logic [3:0] p;
      logic [3:0] s;
      for (int i = 0; i < FEAT; i++) feat_v[i] = 4'($urandom_range(0, 15));
      for (int i = 0; i < FILT; i++) tap_v[i]  = 4'($urandom_range(0, 15));
      p = 4'($urandom_range(0, 4));
      s = 4'($urandom_range(0, 3));
      model(int'(p), int'(s));
      do_reset_a(); run_job(p, s, 1'b0);
    end

    // Kernel longer than the unpadded feature: no results at all.
    @(negedge clk);
    rst_b = 1'b0;
    bus_b.pad = 4'd0;
    bus_b.stride = 4'd1;
    for (int i = 0; i < FEAT; i++) begin
      bus_b.feature = 4'($urandom_range(1, 15));
      repeat (DIV) @(negedge clk);
    end
    for (int i = 0; i < FILT_B; i++) begin
      bus_b.filter = 4'($urandom_range(1, 15));
      repeat (DIV) @(negedge clk);
    end
    repeat (4) @(negedge clk);
    $display("job: filt_len=8 pad=0 pulses=%0d out=%0d", pulses_b, bus_b.out);
    cmp("l0_pulses", pulses_b, 0);
    cmp("l0_out", int'(bus_b.out), 0);
    cmp("l0_check", int'(bus_b.check), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
